// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO between the master module and the memory controller.
// Supports standard registered read or first-word-fall-through, occupancy count, thresholds and sticky error flags.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                    clk_mem,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    input  logic                    clr_err,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags decode only the registered count, so no input reaches an output combinationally.
    always_comb begin
        full         = (count == DEPTH_C);
        empty        = (count == '0);
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
    end

    // A full FIFO refuses writes even when a read frees a slot in the same cycle.
    always_comb begin
        wr_acc = wr_en && !full;
        rd_acc = rd_en && !empty;
    end

    always_ff @(posedge clk_mem) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky errors: a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            always_comb begin
                data_out = empty ? '0 : mem[rd_ptr];
            end
        end else begin : g_std
            always_ff @(posedge clk_mem or posedge reset) begin
                if (reset) begin
                    data_out <= '0;
                end else if (rd_acc) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: standard and FWFT instances share one stimulus stream
// and are compared every cycle against a queue-based model, plus directed literal expectations.
module tb_sync_fifo_param;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 16;

    logic          clk_mem = 1'b0;
    logic          reset   = 1'b1;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en   = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] dout0, dout1;
    logic          full0, empty0, af0, ae0, ovf0, udf0;
    logic          full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0]    cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk_mem = ~clk_mem;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)) dut_std (
        .clk_mem(clk_mem), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)) dut_fwft (
        .clk_mem(clk_mem), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy is the queue, outputs follow from its size and head.
    logic [DW-1:0] q[$];
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;
    logic [DW-1:0] m_dout0 = '0;

    always @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_dout0 = '0;
        end else begin
            if (wr_en && q.size() == DP) m_ovf = 1'b1;
            else if (clr_err)            m_ovf = 1'b0;
            if (rd_en && q.size() == 0)  m_udf = 1'b1;
            else if (clr_err)            m_udf = 1'b0;
            if (wr_en && q.size() < DP) begin
                if (rd_en && q.size() > 0) begin
                    m_dout0 = q.pop_front();
                end
                q.push_back(data_in);
            end else if (rd_en && q.size() > 0) begin
                m_dout0 = q.pop_front();
            end
        end
    end

    always @(negedge clk_mem) begin
        check("count_std",  32'(cnt0), 32'(q.size()));
        check("count_fwft", 32'(cnt1), 32'(q.size()));
        check("full",  32'({full0, full1}),   {30'd0, {2{q.size() == DP}}});
        check("empty", 32'({empty0, empty1}), {30'd0, {2{q.size() == 0}}});
        check("almost_full",  32'({af0, af1}), {30'd0, {2{q.size() >= 14}}});
        check("almost_empty", 32'({ae0, ae1}), {30'd0, {2{q.size() <= 2}}});
        check("overflow",  32'({ovf0, ovf1}), {30'd0, {2{m_ovf}}});
        check("underflow", 32'({udf0, udf1}), {30'd0, {2{m_udf}}});
        check("dout_std",  32'(dout0), 32'(m_dout0));
        check("dout_fwft", 32'(dout1), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk_mem);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_mem);
        #1 reset = 1'b0;
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_flags", 32'({empty0, full0, ae0, af0, ovf0, udf0}), 32'b101000);
        check("rst_dout",  32'({dout0, dout1}), 32'd0);

        // Fill: almost_full first appears at count 14.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 12) check("af_at13", 32'(af0), 32'd0);
            if (i == 13) check("af_at14", 32'(af0), 32'd1);
        end
        check("fill_full",  32'({full0, cnt0}), 32'h30);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_17th",   32'({ovf0, cnt0}), 32'h30);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf",    32'(ovf0), 32'd0);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        check("set_wins",   32'(ovf1), 32'd1);

        // Simultaneous at full: the read wins, 0x77 is dropped.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("full_wr_rd_cnt",  32'(cnt0), 32'd15);
        check("full_wr_rd_dout", 32'(dout0), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("fwft_head", 32'(dout1), 32'h01);

        for (int i = 1; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_dout", 32'(dout0), 32'(i));
            if (i == 12) check("ae_at3", 32'(ae0), 32'd0);
            if (i == 13) check("ae_at2", 32'(ae0), 32'd1);
        end
        check("drain_empty", 32'({empty0, cnt0}), 32'h20);

        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_empty_rd", 32'({udf0, dout0}), 32'h10F);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("empty_wr_rd_cnt", 32'(cnt0), 32'd1);
        check("fwft_5a",         32'(dout1), 32'h5A);
        check("std_hold",        32'(dout0), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("fwft_5a_hold",    32'(dout1), 32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_ack",        32'({empty1, dout1}), 32'h100);
        check("std_5a",          32'(dout0), 32'h5A);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous at count 7 leaves count unchanged.
        for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b1, 1'b0);
        check("mid_wr_rd_cnt",  32'(cnt0), 32'd7);
        check("mid_wr_rd_dout", 32'(dout0), 32'h30);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("mid_last", 32'({cnt0, dout0}), 32'h40);

        // Pointer wrap.
        for (int i = 0; i < 12; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
        check("wrap_head", 32'(dout1), 32'hA0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_dout", 32'(dout0), 32'(8'hA0 + i));
        end
        check("wrap_cnt", 32'(cnt0), 32'd0);

        // Asynchronous reset mid-stream with count 5 and underflow set.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        check("pre_rst", 32'({udf0, cnt0}), 32'h25);
        #3 reset = 1'b1;
        #1;
        check("arst_cnt",   32'({cnt0, cnt1}), 32'd0);
        check("arst_flags", 32'({empty0, full0, ae0, af0, ovf0, udf0}), 32'b101000);
        check("arst_dout",  32'({dout0, dout1}), 32'd0);
        @(posedge clk_mem);
        #1 reset = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_udf", 32'(udf0), 32'd1);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        check("post_rst_wr", 32'({cnt1, dout1}), 32'h199);

        repeat (2) @(posedge clk_mem);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for the memory-controller domain. Next generation of the fixed 8-bit, fixed-depth exchange buffer between the master module and the memory controller. Adds:
- configurable width and depth
- occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode

## Interface
- DATA_WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk_mem  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- rd_en  input  1  read request
- clr_err  input  1  synchronous clear of overflow/underflow
- data_out  output  DATA_WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_THRESH
- almost_empty  output  1  count ≤ AE_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH × DATA_WIDTH array. Not reset.
- Pointers: wr_ptr and rd_ptr, $clog2(DEPTH) bits each. Each wraps DEPTH-1 → 0 by natural overflow.
- Write accepted iff wr_en && !full. Stores data_in at wr_ptr, then wr_ptr+1.
- Read accepted iff rd_en && !empty. rd_ptr+1.
- Full and simultaneous wr_en, rd_en: the read is accepted and the write is rejected. Write acceptance never depends on rd_en in the same cycle.
- Empty and simultaneous wr_en, rd_en: the write is accepted and the read is rejected.
- count update:
  - +1 on an accepted write only
  - −1 on an accepted read only
  - unchanged when both or neither are accepted
- full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- overflow sets on any cycle with wr_en && full. underflow sets on any cycle with rd_en && empty.
- Both flags hold until clr_err. If set and clear occur in the same cycle, set wins.
- FWFT=0:
  - data_out registered; loads mem[rd_ptr] on the edge that accepts a read.
  - Otherwise holds its last value, including across rejected reads.
- FWFT=1:
  - data_out = mem[rd_ptr] while !empty, all-zero while empty (combinational from registered state).
  - rd_en acknowledges and discards the presented word.
- Reset (async, any time, including mid-burst): pointers = 0, count = 0, data_out = 0, overflow = underflow = 0. Contents are discarded.
- Reset values of the flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AF_THRESH ≥ 1).

## Timing
- Write-to-visibility: a word written on edge N raises count and clears empty after edge N.
  - FWFT=1: data_out shows the word after edge N.
  - FWFT=0: the word is readable by rd_en sampled at edge N+1; data_out is valid after edge N+1.
- Read latency: FWFT=0 is one cycle (rd_en sampled at edge N, data after edge N). FWFT=1 is zero cycles (data present before rd_en).
- Throughput: one write and one read per cycle, sustained.
- Flags change only after clock edges or on asynchronous reset assertion. No combinational path from wr_en or rd_en to any output.
- Reset deassertion: the first operation is accepted on the first rising edge after reset falls.

## Test plan
- Reset: assert reset mid-stream with count=5 → immediately count=0, empty=1, data_out=0x00, flags 0. After release, a read sets underflow=1.
- Fill/drain (DEPTH=16, FWFT=0):
  - Write 0x00..0x0F → full=1, count=16, almost_full asserted at count=14.
  - 17th write → overflow=1, count stays 16.
  - Read 16 → data_out 0x00..0x0F in order, each one cycle after rd_en; almost_empty at count=2; empty=1 after the last read.
- Wrap-around: 12 writes, 12 reads, then 10 writes of 0xA0..0xA9 and 10 reads → data order preserved across the pointer wrap; count returns to 0.
- Simultaneous: wr_en+rd_en at count=16 → count 15, data_in dropped, overflow=1. At count=0 → count 1, underflow=1. At count=7 → count stays 7.
- FWFT=1: write 0x5A to an empty FIFO → data_out=0x5A the next cycle with no rd_en. Assert rd_en → empty=1, data_out=0x00.
- Error clear: overflow=1, then clr_err alone → 0. clr_err together with a write while full → overflow stays 1.
